// File: rtl/key_pkg.sv
// Shared definitions for the keyboard command queue.
//   - KEY_CODE_W    : default width of a key code / command token
//   - KEY_* codes   : key codes produced by the PS/2 event decoder
//   - key_fsm_e     : typematic FSM state encoding
//   - max_int()     : elaboration-time helper for sizing the typematic timer
package key_pkg;

  localparam int KEY_CODE_W = 4;

  localparam logic [KEY_CODE_W-1:0] KEY_NONE  = 4'd0;
  localparam logic [KEY_CODE_W-1:0] KEY_UP    = 4'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_DOWN  = 4'd2;
  localparam logic [KEY_CODE_W-1:0] KEY_LEFT  = 4'd3;
  localparam logic [KEY_CODE_W-1:0] KEY_RIGHT = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_ENTER = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_fsm_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding command tokens.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push, din: write request and token
//   pop      : read request (ignored when empty)
//   dout     : head token, EMPTY_VAL when empty
//   fill     : occupancy 0..DEPTH, kept in its own counter
//   full, empty : status flags
// A push while full is accepted only if a pop happens in the same cycle.
module cmd_fifo #(
  parameter int              WIDTH     = 4,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the empty mask keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? EMPTY_VAL : mem[rd_ptr];
  assign fill = cnt;

endmodule

// File: rtl/key_cmd_queue.sv
// Turns the keyboard decoder's level-type held-key code into one-per-action
// command tokens and queues them for the game logic (valid/ready).
//   clk, rst  : clock, synchronous active-high reset
//   key_state : currently held key code (level), IDLE_CODE = nothing held
//   cmd_ready : consumer takes the head token this cycle
//   cmd_valid : queue non-empty
//   cmd_code  : head token, IDLE_CODE when empty
//   fill      : queue occupancy 0..DEPTH
//   overflow  : sticky, a token was dropped because the queue was full
// Build option: define KEY_AUTOREPEAT_EN for typematic delay/auto-repeat.
// Without it one token is produced per press or per code change, and
// DELAY_CYC/REPEAT_CYC have no effect.
module key_cmd_queue
  import key_pkg::*;
#(
  parameter int                CODE_W     = KEY_CODE_W,
  parameter int                DEPTH      = 4,
  parameter int                DELAY_CYC  = 50000000,
  parameter int                REPEAT_CYC = 10000000,
  parameter logic [CODE_W-1:0] IDLE_CODE  = CODE_W'(KEY_NONE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CODE_W-1:0]      key_state,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [CODE_W-1:0]      cmd_code,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow
);

  logic [CODE_W-1:0] key_p0;
  logic [CODE_W-1:0] last_code;
  key_fsm_e          state;
  key_fsm_e          state_nx;
  logic              push_req;
  logic [CODE_W-1:0] push_code;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef KEY_AUTOREPEAT_EN
  localparam int TMR_MAX = max_int(DELAY_CYC, REPEAT_CYC);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nx;
  logic             delay_done;
  logic             repeat_done;

  assign delay_done  = (timer == TMR_W'(DELAY_CYC - 1));
  assign repeat_done = (timer == TMR_W'(REPEAT_CYC - 1));
`endif

  // Stage p0: key code register; every FSM decision looks at key_p0.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_p0    <= IDLE_CODE;
      state     <= ST_IDLE;
      last_code <= IDLE_CODE;
`ifdef KEY_AUTOREPEAT_EN
      timer     <= '0;
`endif
    end else begin
      key_p0 <= key_state;
      state  <= state_nx;
      if (push_req) last_code <= push_code;
`ifdef KEY_AUTOREPEAT_EN
      timer  <= timer_nx;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
`ifdef KEY_AUTOREPEAT_EN
    timer_nx = timer + 1'b1;
`endif
    case (state)
      ST_IDLE: begin
        if (key_p0 != IDLE_CODE) state_nx = ST_DELAY;
`ifdef KEY_AUTOREPEAT_EN
        timer_nx = '0;
`endif
      end
      ST_DELAY: begin
        if (key_p0 == IDLE_CODE) begin
          state_nx = ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
          timer_nx = '0;
`endif
        end else if (key_p0 != last_code) begin
          state_nx = ST_DELAY;
`ifdef KEY_AUTOREPEAT_EN
          timer_nx = '0;
`endif
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (delay_done) begin
          state_nx = ST_REPEAT;
          timer_nx = '0;
        end
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (key_p0 == IDLE_CODE) begin
          state_nx = ST_IDLE;
          timer_nx = '0;
        end else if (key_p0 != last_code) begin
          state_nx = ST_DELAY;
          timer_nx = '0;
        end else if (repeat_done) begin
          timer_nx = '0;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
        timer_nx = '0;
`endif
      end
    endcase
  end

  // Push decode. On a repeat push key_p0 equals last_code, so the token is
  // always the registered key code.
  always_comb begin
    push_req  = 1'b0;
    push_code = key_p0;
    case (state)
      ST_IDLE:  push_req = (key_p0 != IDLE_CODE);
      ST_DELAY: begin
        if (key_p0 != IDLE_CODE) begin
          if (key_p0 != last_code) push_req = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          else if (delay_done)     push_req = 1'b1;
`endif
        end
      end
`ifdef KEY_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (key_p0 != IDLE_CODE) begin
          if (key_p0 != last_code) push_req = 1'b1;
          else if (repeat_done)    push_req = 1'b1;
        end
      end
`endif
      default:  push_req = 1'b0;
    endcase
  end

  // Stage p1: token queue towards the game logic.
  assign cmd_valid = ~fifo_empty;
  assign pop       = cmd_valid & cmd_ready;

  cmd_fifo #(
    .WIDTH     (CODE_W),
    .DEPTH     (DEPTH),
    .EMPTY_VAL (IDLE_CODE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (push_code),
    .pop   (pop),
    .dout  (cmd_code),
    .fill  (fill),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push into a full queue survives only if the head leaves this cycle.
  always_ff @(posedge clk) begin
    if (rst)                              overflow <= 1'b0;
    else if (push_req & fifo_full & ~pop) overflow <= 1'b1;
  end

endmodule

// File: doc/key_cmd_queue.md
Name: key_cmd_queue

Overview:
- Sits between the PS/2 keyboard event decoder and the single-player game logic.
- Converts the decoder's level-type 4-bit "current key" code into discrete one-per-action command tokens, with typematic delay and auto-repeat.
- Buffers tokens in a small FIFO and hands them to the game through a valid/ready handshake, so no move is lost or duplicated while the game is busy.

Parameters:
- CODE_W, 4, width of key code and command token.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DELAY_CYC, 50000000, cycles a key must be held before the first repeat (500 ms at 100 MHz).
- REPEAT_CYC, 10000000, cycles between repeats once repeating (100 ms).
- IDLE_CODE, 0, key code meaning "no key held".

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- key_state  in  CODE_W  current held-key code from the keyboard decoder, level signal
- cmd_ready  in  1  consumer accepts head token this cycle
- cmd_valid  out  1  FIFO non-empty
- cmd_code  out  CODE_W  head token; IDLE_CODE when empty
- fill  out  clog2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: a token was dropped because the FIFO was full

Behaviour:
- Reset values: cmd_valid=0, cmd_code=IDLE_CODE, fill=0, overflow=0. FSM=IDLE, timer=0, last_code=IDLE_CODE, pointers=0. Reset mid-operation discards all queued tokens.
- key_state is registered once (key_q). All decisions use key_q.
- FSM states:
  - IDLE: key_q!=IDLE_CODE → push key_q, timer=0, go DELAY.
  - DELAY:
    - key_q==IDLE_CODE → IDLE.
    - key_q!=last_code (non-idle) → push new code, timer=0, stay DELAY.
    - timer==DELAY_CYC-1 → push last_code, timer=0, go REPEAT.
    - else timer+1.
  - REPEAT:
    - key_q==IDLE_CODE → IDLE.
    - code change → push, timer=0, go DELAY.
    - timer==REPEAT_CYC-1 → push, timer=0.
    - else timer+1.
- last_code updates on every push.
- Latency: key_state change at edge N, key_q at N+1, push at N+2, cmd_valid high after edge N+2.
- Timer width is clog2 of max(DELAY_CYC, REPEAT_CYC). The timer never wraps; it is cleared on every push and on entry to IDLE.
- FIFO:
  - pop = cmd_valid & cmd_ready.
  - cmd_code is driven from the registered head entry and is stable while cmd_valid is high and cmd_ready is low.
  - Push when full without pop: token dropped, overflow set until rst.
  - Push and pop in the same cycle when full: both occur, fill unchanged, no overflow.
  - Push and pop in the same cycle when fill=1: token passes through, cmd_valid stays 1.
  - Pop when empty: ignored.
  - cmd_ready asserted while cmd_valid=0 has no effect.
- Pointers wrap modulo DEPTH. fill is computed from a separate counter, not pointer difference.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined: full IDLE/DELAY/REPEAT behaviour as above.
- Undefined: no timer logic. DELAY acts as HELD and never times out. REPEAT is unreachable. Exactly one token per press or per code change. DELAY_CYC and REPEAT_CYC are ignored.

Decomposition:
- Package key_pkg holds:
  - key code constants: KEY_NONE=0, KEY_UP=1, KEY_DOWN=2, KEY_LEFT=3, KEY_RIGHT=4, KEY_ENTER=5.
  - FSM state encoding: IDLE=0, DELAY=1, REPEAT=2.
  - CODE_W default.
- One sub-module, cmd_fifo: synchronous FIFO parameterised by width and depth, with push, pop, head data, fill, full, empty.
- The FSM and timer live in key_cmd_queue.

Test Plan (sim with DELAY_CYC=8, REPEAT_CYC=4, DEPTH=4):
- Press code 1 for 3 cycles, then 0, with cmd_ready=1 → exactly one token 1; cmd_valid first high 2 cycles after the key_state edge.
- Hold code 3 for 20 cycles with cmd_ready=1 → tokens at push offsets 0, 8, 12, 16: four tokens of 3 (with KEY_AUTOREPEAT_EN). Without the macro → one token.
- Hold 2, then switch to 4 after 5 cycles → tokens 2, 4. The switch restarts the delay, so the next repeat of 4 comes 8 cycles later.
- cmd_ready=0, press 1,2,1,2,1 as separate presses → fill=4, head stays 1, overflow=1, 5th token dropped. Then cmd_ready=1 → tokens 1,2,1,2 in order.
- FIFO full, cmd_ready=1 and a new push in the same cycle → fill stays 4, overflow stays 0, order preserved.
- Assert rst while fill=3 and in REPEAT → next cycle: cmd_valid=0, fill=0, overflow=0. A still-held key is re-accepted as a new press 2 cycles after rst deasserts.
